div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-low; sampled on the rising edge of clk.
REQ-003 start  input  1  request a division; sampled only in IDLE.
REQ-004 a  input  32  dividend, two's complement (A register value).
REQ-005 b  input  32  divisor, two's complement (B register value).
REQ-006 hi  output  32  remainder; registered; feeds the HI mux.
REQ-007 lo  output  32  quotient; registered; feeds the LO mux.
REQ-008 busy  output  1  high while iterating (CALC state).
REQ-009 done  output  1  one-cycle pulse; hi/lo valid and new.
REQ-010 div0  output  1  one-cycle pulse; divide-by-zero detected; drives the control unit's Div0 flag.

Function
REQ-011 The FSM SHALL have three states, IDLE, CALC and DONE, with an encoding defined in the shared package.
REQ-012 In IDLE, start=1 with b!=0 SHALL, at that edge, latch |a|, |b|, sign(a) and sign(a)^sign(b), clear the partial remainder, clear the step counter, and go to CALC.
REQ-013 In IDLE, start=1 with b==0 SHALL set div0=1 for the next cycle only, stay in IDLE, and leave hi, lo and done unchanged.
REQ-014 CALC SHALL perform one unsigned restoring step per edge: shift the remainder left, pull in the dividend MSB, subtract |b| if the result is non-negative, and shift the quotient bit in.
REQ-015 After exactly 32 CALC edges, that edge SHALL register the sign-corrected results into hi/lo and go to DONE.
REQ-016 Quotient sign SHALL be negative iff sign(a)^sign(b); remainder sign SHALL follow sign(a); truncation SHALL be toward zero (MIPS DIV).
REQ-017 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0, with no flag.
REQ-018 done SHALL be 1 only in DONE; DONE SHALL last exactly one cycle, then return to IDLE.
REQ-019 Latency: if start is sampled at edge E0, done SHALL be high in the cycle after edge E32.
REQ-020 busy SHALL equal (state==CALC).
REQ-021 start SHALL be ignored in CALC and DONE.
REQ-022 a and b SHALL be ignored after the start edge; changing them mid-operation SHALL not affect the result.
REQ-023 hi/lo SHALL hold their last value in all states except the final CALC edge.
REQ-024 Absolute values SHALL be formed in 32 bits; |0x80000000| SHALL be treated as unsigned 0x80000000.

Reset
REQ-025 When reset=0 at a clock edge, the block SHALL go to IDLE and clear hi, lo, the counter and all internal registers to 0, with busy=0, done=0, div0=0.
REQ-026 Reset during CALC or DONE SHALL abort the operation, with no done or div0 pulse afterwards.
REQ-027 The first start SHALL be accepted on the first edge with reset=1.

Structure
REQ-028 The shared package SHALL hold the state type (IDLE/CALC/DONE) and the constant DIV_STEPS=32; the counter width SHALL be derived from DIV_STEPS.
REQ-029 One combinational sub-module, div_step, SHALL implement a single restoring iteration: inputs are remainder, quotient and divisor; outputs are the next remainder and next quotient.
REQ-030 All outputs SHALL be driven directly from registers or from the state decode, with no combinational path from a or b to the outputs.

Verification
REQ-031 a=100, b=7, start pulse -> busy for 32 cycles; done in the cycle after E32; lo=14, hi=2.
REQ-032 a=-100 (0xFFFFFF9C), b=7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2); also a=100, b=-7 -> lo=-14, hi=2.
REQ-033 a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div0=0.
REQ-034 Prior result loaded, then a=5, b=0, start -> div0 high for exactly 1 cycle, busy=0, done=0, hi/lo unchanged.
REQ-035 Start a division, assert reset=0 at cycle 10 -> next cycle all outputs 0 and IDLE; no done follows; a new start then completes normally.
REQ-036 Second start pulse and changed a/b during CALC -> ignored; the first result completes, and exactly one done pulse occurs.

Source files
------------

// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared state type, step count and helpers for the sequential divider
package div_seq_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
  localparam int DIV_STEPS = 32;
  localparam int CNT_W = $clog2(DIV_STEPS);
  // 0x80000000 maps to itself, which is its correct unsigned magnitude
  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? -x : x;
  endfunction
endpackage

// File: rtl/div_seq_step.sv
// div_step: one unsigned restoring iteration; quo shifts dividend bits out and quotient bits in
module div_step (
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] dvs,
  output logic [31:0] rem_nx,
  output logic [31:0] quo_nx
);
  logic [32:0] sh, diff;
  always_comb begin
    sh = {rem, quo[31]};
    diff = sh - {1'b0, dvs};
    rem_nx = diff[32] ? sh[31:0] : diff[31:0];
    quo_nx = {quo[30:0], ~diff[32]};
  end
endmodule

// File: rtl/div_seq.sv
// div_seq: 32-cycle signed restoring divider (MIPS DIV semantics) with div-by-zero flag
module div_seq
  import div_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div0
);
  state_t state, state_nx;
  logic [31:0] rem, quo, dvs, rem_nx, quo_nx;
  logic neg_q, neg_r, last, accept, zero_div;
  logic [CNT_W-1:0] cnt;
  div_step u_step (.rem(rem), .quo(quo), .dvs(dvs), .rem_nx(rem_nx), .quo_nx(quo_nx));
  assign last = cnt == CNT_W'(DIV_STEPS - 1);
  assign accept = state == IDLE && start && b != '0;
  assign zero_div = state == IDLE && start && b == '0;
  assign busy = state == CALC;
  assign done = state == DONE;
  always_comb begin
    state_nx = IDLE;
    state_nx = state == IDLE ? (accept ? CALC : IDLE) :
               state == CALC ? (last ? DONE : CALC) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      div0 <= 1'b0;
    end else begin
      state <= state_nx;
      div0 <= zero_div;
      if (accept) begin
        rem <= '0;
        quo <= abs32(a);
        dvs <= abs32(b);
        neg_r <= a[31];
        neg_q <= a[31] ^ b[31];
        cnt <= '0;
      end else if (state == CALC) begin
        rem <= rem_nx;
        quo <= quo_nx;
        cnt <= cnt + 1'b1;
        if (last) begin
          hi <= neg_r ? -rem_nx : rem_nx;
          lo <= neg_q ? -quo_nx : quo_nx;
        end
      end
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: table-driven, random and corner-sequence checks of div_seq against an arithmetic model
module tb_div_seq;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [31:0] a_i = '0, b_i = '0;
  logic [31:0] hi, lo;
  logic busy, done, div0;
  int n_chk = 0, n_fail = 0;

  div_seq dut (.clk(clk), .reset(reset), .start(start), .a(a_i), .b(b_i),
               .hi(hi), .lo(lo), .busy(busy), .done(done), .div0(div0));

  always #5 clk = ~clk;

  typedef struct {logic [31:0] a, b, hi, lo;} vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input string tag);
    int cyc, nbusy, ndiv0;
    @(negedge clk);
    a_i = a;
    b_i = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_i = $urandom;
    b_i = $urandom;
    cyc = 0;
    nbusy = 0;
    ndiv0 = 0;
    while (!done && cyc < 100) begin
      nbusy += int'(busy);
      ndiv0 += int'(div0);
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'd32);
    chk({tag, "_div0_quiet"}, 32'(ndiv0), 32'd0);
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, sh, sl;
    logic [63:0] m;
    int ndone;
    tbl[0]  = '{32'd100,       32'd7,         32'd2,         32'd14};
    tbl[1]  = '{32'hFFFFFF9C,  32'd7,         32'hFFFFFFFE,  32'hFFFFFFF2};
    tbl[2]  = '{32'd100,       32'hFFFFFFF9,  32'd2,         32'hFFFFFFF2};
    tbl[3]  = '{32'hFFFFFF9C,  32'hFFFFFFF9,  32'hFFFFFFFE,  32'd14};
    tbl[4]  = '{32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000};
    tbl[5]  = '{32'd0,         32'd5,         32'd0,         32'd0};
    tbl[6]  = '{32'hFFFFFFFF,  32'h80000000,  32'hFFFFFFFF,  32'd0};
    tbl[7]  = '{32'h80000000,  32'd1,         32'd0,         32'h80000000};
    tbl[8]  = '{32'h7FFFFFFF,  32'h80000000,  32'h7FFFFFFF,  32'd0};
    tbl[9]  = '{32'd3,         32'd10,        32'd3,         32'd0};
    tbl[10] = '{32'h80000000,  32'h80000000,  32'd0,         32'd1};

    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_div0", 32'(div0), 32'd0);
    // start is presented in the same cycle reset is released
    reset = 1'b1;
    a_i = 32'd100;
    b_i = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("first_start_busy", 32'(busy), 32'd1);
    ndone = 0;
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    chk("first_start_done", 32'(done), 32'd1);
    chk("first_start_lo", lo, 32'd14);
    @(negedge clk);

    foreach (tbl[i]) do_div(tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if ($urandom_range(0, 3) == 0) rb = -rb;
      if (rb == 0) rb = 32'd1;
      m = model(ra, rb);
      do_div(ra, rb, m[63:32], m[31:0], $sformatf("rnd%0d", i));
    end

    // divide by zero leaves prior result and raises a single-cycle flag
    do_div(32'd100, 32'd7, 32'd2, 32'd14, "pre_div0");
    a_i = 32'd5;
    b_i = 32'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("div0_pulse", 32'(div0), 32'd1);
    chk("div0_busy", 32'(busy), 32'd0);
    chk("div0_done", 32'(done), 32'd0);
    chk("div0_hi", hi, 32'd2);
    chk("div0_lo", lo, 32'd14);
    @(negedge clk);
    chk("div0_cleared", 32'(div0), 32'd0);
    chk("div0_still_idle", 32'(busy), 32'd0);

    // reset in the middle of a calculation
    a_i = 32'd1000;
    b_i = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_div0", 32'(div0), 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      ndone += int'(done) + int'(div0) + int'(busy);
      @(negedge clk);
    end
    chk("abort_no_activity", 32'(ndone), 32'd0);
    do_div(32'd1000, 32'd3, 32'd1, 32'd333, "after_abort");

    // start and operand changes while calculating are ignored
    a_i = 32'hFFFFFC18;
    b_i = 32'd9;
    start = 1'b1;
    @(negedge clk);
    a_i = 32'd77;
    b_i = 32'd0;
    repeat (3) @(negedge clk);
    b_i = 32'd5;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    sh = 32'hDEADBEEF;
    sl = 32'hDEADBEEF;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        sh = hi;
        sl = lo;
      end
      ndone += int'(done);
      @(negedge clk);
    end
    chk("midop_done_count", 32'(ndone), 32'd1);
    chk("midop_hi", sh, 32'hFFFFFFFF);
    chk("midop_lo", sl, 32'hFFFFFF91);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
